// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end blocks.
// Holds the window geometry, default image sizing and the sequencer state type.
package cnn_pkg;

    localparam int KERNEL     = 3;
    localparam int PATCH_SIZE = KERNEL * KERNEL;

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        LOAD,
        VALID,
        DONE
    } state_t;

endpackage

// File: rtl/patch_addr_gen_if.sv
// Handshake and address bus between the patch sequencer (master) and the
// patch latch / convolution stage (slave).
interface patch_addr_gen_if
    import cnn_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int COORD_W = 5
);

    logic               start;
    logic               ready;
    logic [ADDR_W-1:0]  pixel_addrs [PATCH_SIZE];
    logic               load;
    logic               patch_valid;
    logic [COORD_W-1:0] out_row;
    logic [COORD_W-1:0] out_col;
    logic               busy;
    logic               done;

    modport master (
        input  start, ready,
        output pixel_addrs, load, patch_valid, out_row, out_col, busy, done
    );

    modport slave (
        output start, ready,
        input  pixel_addrs, load, patch_valid, out_row, out_col, busy, done
    );

endinterface

// File: rtl/window_addr_calc.sv
// Expands a window's top-left address into the nine row-major pixel addresses.
// Purely combinational so later conv layers can reuse it with their own sequencing.
module window_addr_calc
    import cnn_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addrs [PATCH_SIZE]
);

    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        for (genvar c = 0; c < KERNEL; c++) begin : g_col
            assign addrs[KERNEL*r+c] = base + ADDR_W'(r * IMG_W + c);
        end
    end

endmodule

// File: rtl/patch_addr_gen.sv
// Raster-order 3x3 patch sequencer: issues nine read addresses, waits out the
// memory latency, pulses load, then holds patch_valid until ready.
module patch_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int STRIDE  = 1,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int MEM_LAT = 1,
    parameter int COORD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    patch_addr_gen_if.master  bus
);

    localparam int OUT_W  = (IMG_W - KERNEL) / STRIDE + 1;
    localparam int OUT_H  = (IMG_H - KERNEL) / STRIDE + 1;
    localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0]  COL_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(OUT_W - 1);
    localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(OUT_H - 1);

    if (IMG_W * IMG_H > 2 ** ADDR_W) begin : g_addr_w_check
        $error("patch_addr_gen: IMG_W*IMG_H does not fit in ADDR_W bits");
    end

    state_t             state, state_next;
    logic [ADDR_W-1:0]  base, base_next;
    logic [ADDR_W-1:0]  row_base, row_base_next;
    logic [COORD_W-1:0] row, row_next;
    logic [COORD_W-1:0] col, col_next;
    logic [WAIT_W-1:0]  wait_cnt, wait_next;
    logic               addr_en;
    logic [ADDR_W-1:0]  addrs_next [PATCH_SIZE];

    // Addresses are computed from the next base so they register together with it.
    window_addr_calc #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_calc (
        .base  (base_next),
        .addrs (addrs_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            row_base <= '0;
            row      <= '0;
            col      <= '0;
            wait_cnt <= '0;
            for (int i = 0; i < PATCH_SIZE; i++) begin
                bus.pixel_addrs[i] <= '0;
            end
        end else begin
            state    <= state_next;
            base     <= base_next;
            row_base <= row_base_next;
            row      <= row_next;
            col      <= col_next;
            wait_cnt <= wait_next;
            if (addr_en) begin
                bus.pixel_addrs <= addrs_next;
            end
        end
    end

    always_comb begin
        state_next    = state;
        base_next     = base;
        row_base_next = row_base;
        row_next      = row;
        col_next      = col;
        wait_next     = wait_cnt;
        addr_en       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    base_next     = '0;
                    row_base_next = '0;
                    row_next      = '0;
                    col_next      = '0;
                    addr_en       = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                wait_next  = '0;
                state_next = (MEM_LAT > 1) ? WAIT : LOAD;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_next = LOAD;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            LOAD: state_next = VALID;
            VALID: begin
                if (bus.ready) begin
                    if (row == LAST_ROW && col == LAST_COL) begin
                        state_next = DONE;
                    end else begin
                        // Wrapping to a new row restarts from the row base, not base+STRIDE.
                        if (col == LAST_COL) begin
                            col_next      = '0;
                            row_next      = row + 1'b1;
                            row_base_next = row_base + ROW_STEP;
                            base_next     = row_base + ROW_STEP;
                        end else begin
                            col_next  = col + 1'b1;
                            base_next = base + COL_STEP;
                        end
                        addr_en    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.load        = (state == LOAD);
    assign bus.patch_valid = (state == VALID);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.out_row     = row;
    assign bus.out_col     = col;

endmodule

// File: tb/tb_patch_addr_gen.sv
// Bench for patch_addr_gen: stride-1/latency-1 and stride-2/latency-3 instances
// compared cycle by cycle against a raster-scan reference model.
module tb_patch_addr_gen;

    localparam int IMG = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors = 0;
    int errors  = 0;

    logic [9:0] o_addr [9];
    logic       o_load, o_pv, o_busy, o_done;
    logic [4:0] o_row, o_col;

    int done_at, loads, last_a0, last_a8;

    always #5 clk = ~clk;

    patch_addr_gen_if #(.ADDR_W(10), .COORD_W(5)) ifa ();
    patch_addr_gen_if #(.ADDR_W(10), .COORD_W(5)) ifb ();

    patch_addr_gen #(
        .IMG_W(IMG), .IMG_H(IMG), .STRIDE(1), .ADDR_W(10), .MEM_LAT(1), .COORD_W(5)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    patch_addr_gen #(
        .IMG_W(IMG), .IMG_H(IMG), .STRIDE(2), .ADDR_W(10), .MEM_LAT(3), .COORD_W(5)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        for (int i = 0; i < 9; i++) begin
            o_addr[i] = (sel == 0) ? ifa.pixel_addrs[i] : ifb.pixel_addrs[i];
        end
        o_load = (sel == 0) ? ifa.load        : ifb.load;
        o_pv   = (sel == 0) ? ifa.patch_valid : ifb.patch_valid;
        o_busy = (sel == 0) ? ifa.busy        : ifb.busy;
        o_done = (sel == 0) ? ifa.done        : ifb.done;
        o_row  = (sel == 0) ? ifa.out_row     : ifb.out_row;
        o_col  = (sel == 0) ? ifa.out_col     : ifb.out_col;
    endtask

    task automatic drive(input int sel, input logic s, input logic r);
        ifa.start = (sel == 0) && s;
        ifa.ready = (sel == 0) && r;
        ifb.start = (sel == 1) && s;
        ifb.ready = (sel == 1) && r;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_load"}, o_load, 0);
        chk({tag, "_pv"},   o_pv,   0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_row"},  o_row,  0);
        chk({tag, "_col"},  o_col,  0);
        for (int i = 0; i < 9; i++) chk({tag, "_addr"}, o_addr[i], 0);
    endtask

    // One full-image scan against the model; called at a negedge with the DUT idle.
    task automatic run_scan(input int sel, input int stride, input int mem_lat,
                            input bit rnd, input int abort_k,
                            output int d_at, output int n_load,
                            output int a0, output int a8);
        int  out_w, total, k, issue_cyc, vcnt, base, r, c;
        bit  rdy, fin;
        out_w     = (IMG - 3) / stride + 1;
        total     = out_w * out_w;
        k         = 0;
        issue_cyc = 1;
        vcnt      = 0;
        d_at      = -1;
        n_load    = 0;
        a0        = -1;
        a8        = -1;
        fin       = 0;
        drive(sel, 1'b1, 1'b0);
        for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
            @(negedge clk);
            sample(sel);
            chk("done",        o_done, cyc == d_at);
            chk("busy",        o_busy, (k < total) || (cyc <= d_at));
            chk("load",        o_load, (k < total) && (cyc == issue_cyc + mem_lat));
            chk("patch_valid", o_pv,   (k < total) && (cyc > issue_cyc + mem_lat));
            if (k < total) begin
                r    = k / out_w;
                c    = k % out_w;
                base = r * stride * IMG + c * stride;
                chk("out_row", o_row, r);
                chk("out_col", o_col, c);
                for (int i = 0; i < 9; i++) chk("addr", o_addr[i], base + (i / 3) * IMG + i % 3);
            end
            if (o_load) begin
                n_load++;
                a0 = o_addr[0];
                a8 = o_addr[8];
            end
            if (abort_k >= 0 && k == abort_k && o_load) begin
                rst = 1'b1;
                drive(sel, 1'b0, 1'b0);
                @(negedge clk);
                sample(sel);
                check_cleared("abort");
                rst = 1'b0;
                @(negedge clk);
                sample(sel);
                check_cleared("abort_idle");
                fin = 1;
            end else if (d_at > 0 && cyc > d_at) begin
                drive(sel, 1'b0, 1'b0);
                fin = 1;
            end else begin
                rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (k < total && cyc > issue_cyc + mem_lat) begin
                    if (rnd && k == 0 && vcnt < 5) rdy = 1'b0;
                    vcnt++;
                    if (rdy) begin
                        k++;
                        vcnt = 0;
                        if (k < total) issue_cyc = cyc + 1;
                        else           d_at      = cyc + 1;
                    end
                end
                drive(sel, $urandom_range(0, 7) == 0, rdy);
            end
        end
        chk("scan_terminated", fin, 1);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sample(0);
        check_cleared("reset_a");
        sample(1);
        check_cleared("reset_b");
        rst = 1'b0;
        @(negedge clk);

        // Stride 1, ready always high: exact cycle and pulse counts.
        run_scan(0, 1, 1, 1'b0, -1, done_at, loads, last_a0, last_a8);
        chk("s1_done_cycle", done_at, 2029);
        chk("s1_loads", loads, 676);
        chk("s1_last_a0", last_a0, 725);
        chk("s1_last_a8", last_a8, 783);

        // Restart right after done, random ready, abort in LOAD of patch 100.
        run_scan(0, 1, 1, 1'b1, 100, done_at, loads, last_a0, last_a8);
        chk("abort_loads", loads, 101);

        run_scan(0, 1, 1, 1'b1, -1, done_at, loads, last_a0, last_a8);
        chk("s1r_loads", loads, 676);

        // Stride 2 with a three-cycle memory latency.
        run_scan(1, 2, 3, 1'b1, -1, done_at, loads, last_a0, last_a8);
        chk("s2_loads", loads, 169);
        chk("s2_last_a0", last_a0, 12 * 2 * IMG + 12 * 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
